lsu_ctrl: RTL and testbench

- Load/store control stage sitting directly upstream of the DPI-backed data memory wrapper; consumes requests from EXE, produces WB results.
- Converts a byte address and access size into an 8-byte-aligned memory access: aligned address, byte write mask, lane-shifted store data.
- Extracts and sign/zero-extends load data.
- Guarantees memory write mask is zero whenever no store is in progress, because the memory commits writes unconditionally.

---
 rtl/lsu_pkg.sv | 49 ++++
 rtl/lsu_if.sv | 44 ++++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu_ctrl.sv | 136 +++++++++++++
 tb/tb_lsu_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store control stage.
// Size encodings, FSM states and per-size byte masks used by lsu_ctrl and lsu_align.
package lsu_pkg;

    localparam int unsigned XLEN_DEF  = 64;
    localparam int unsigned TAG_W_DEF = 5;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_e;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    function automatic logic [7:0] base_mask(input lsu_size_e sz);
        logic [7:0] m;
        unique case (sz)
            SZ_B:    m = MASK_B;
            SZ_H:    m = MASK_H;
            SZ_W:    m = MASK_W;
            default: m = MASK_D;
        endcase
        return m;
    endfunction

    // Natural alignment: the low address bits covered by the access size must be zero.
    function automatic logic is_misaligned(input lsu_size_e sz, input logic [2:0] off);
        logic mis;
        unique case (sz)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            SZ_W:    mis = (off[1:0] != 2'b00);
            default: mis = (off != 3'b000);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request, response and data-memory signals of the LSU grouped into one bundle.
// slave is the LSU's view; master is the EXE/WB/memory environment's view.
interface lsu_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
);

    logic             req_valid;
    logic             req_ready;
    logic [XLEN-1:0]  req_addr;
    logic             req_we;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [XLEN-1:0]  req_wdata;
    logic [TAG_W-1:0] req_tag;

    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_rdata;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;

    logic [XLEN-1:0]  mem_addr;
    logic             mem_ce;
    logic             mem_we;
    logic [XLEN-1:0]  mem_wdata;
    logic [7:0]       mem_wmask;
    logic [XLEN-1:0]  mem_rdata;

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, req_tag,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_tag, resp_err,
        output mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, req_tag,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_tag, resp_err,
        input  mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store mask/data shift into the 8-byte word and
// load shift/truncate/extend out of it. Bytes past the word boundary are dropped.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e   st_size_i,
    input  logic [2:0]  st_off_i,
    input  logic [63:0] st_wdata_i,
    output logic [7:0]  st_wmask_o,
    output logic [63:0] st_wdata_o,

    input  lsu_size_e   ld_size_i,
    input  logic [2:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [63:0] ld_rdata_i,
    output logic [63:0] ld_data_o
);

    logic [63:0] ld_shifted;

    always_comb begin
        st_wmask_o = base_mask(st_size_i) << st_off_i;
        st_wdata_o = st_wdata_i << {st_off_i, 3'b000};
    end

    always_comb begin
        ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_data_o  = ld_shifted;
        unique case (ld_size_i)
            SZ_B: ld_data_o = ld_unsigned_i ? {56'd0, ld_shifted[7:0]}
                                            : {{56{ld_shifted[7]}}, ld_shifted[7:0]};
            SZ_H: ld_data_o = ld_unsigned_i ? {48'd0, ld_shifted[15:0]}
                                            : {{48{ld_shifted[15]}}, ld_shifted[15:0]};
            SZ_W: ld_data_o = ld_unsigned_i ? {32'd0, ld_shifted[31:0]}
                                            : {{32{ld_shifted[31]}}, ld_shifted[31:0]};
            default: ld_data_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage: IDLE -> ACCESS -> RESP FSM with registered memory and response outputs.
// Optional LSU_MISALIGN_CHK_EN: misaligned requests bypass memory and answer with resp_err.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF
) (
    input logic clk,
    input logic rst_n,
    lsu_if.slave bus
);

    lsu_state_e       state_q;
    logic [2:0]       off_q;
    lsu_size_e        size_q;
    logic             unsigned_q;
    logic             we_q;

    logic [XLEN-1:0]  mem_addr_q;
    logic [XLEN-1:0]  mem_wdata_q;
    logic [7:0]       mem_wmask_q;
    logic             mem_ce_q;
    logic             mem_we_q;

    logic             resp_valid_q;
    logic [XLEN-1:0]  resp_rdata_q;
    logic [TAG_W-1:0] resp_tag_q;
    logic             resp_err_q;

    lsu_size_e        req_size;
    logic             req_fire;
    logic             req_misaligned;
    logic [7:0]       st_wmask;
    logic [63:0]      st_wdata;
    logic [63:0]      ld_data;

    assign req_size = lsu_size_e'(bus.req_size);
    assign req_fire = bus.req_valid && bus.req_ready;

`ifdef LSU_MISALIGN_CHK_EN
    assign req_misaligned = is_misaligned(req_size, bus.req_addr[2:0]);
`else
    assign req_misaligned = 1'b0;
`endif

    // Store lanes come from the live request so they can be registered at acceptance;
    // load lanes use the latched offset against memory data read during ACCESS.
    lsu_align u_align (
        .st_size_i     (req_size),
        .st_off_i      (bus.req_addr[2:0]),
        .st_wdata_i    (bus.req_wdata),
        .st_wmask_o    (st_wmask),
        .st_wdata_o    (st_wdata),
        .ld_size_i     (size_q),
        .ld_off_i      (off_q),
        .ld_unsigned_i (unsigned_q),
        .ld_rdata_i    (bus.mem_rdata),
        .ld_data_o     (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            off_q        <= 3'd0;
            size_q       <= SZ_B;
            unsigned_q   <= 1'b0;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= 8'h00;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_tag_q   <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        off_q      <= bus.req_addr[2:0];
                        size_q     <= req_size;
                        unsigned_q <= bus.req_unsigned;
                        we_q       <= bus.req_we;
                        resp_tag_q <= bus.req_tag;
                        if (req_misaligned) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= '0;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state_q     <= ACCESS;
                            mem_ce_q    <= 1'b1;
                            mem_we_q    <= bus.req_we;
                            mem_addr_q  <= {bus.req_addr[XLEN-1:3], 3'b000};
                            // The memory commits writes unconditionally, so loads carry no mask.
                            mem_wmask_q <= bus.req_we ? st_wmask : 8'h00;
                            mem_wdata_q <= bus.req_we ? st_wdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    state_q      <= RESP;
                    mem_ce_q     <= 1'b0;
                    mem_we_q     <= 1'b0;
                    mem_addr_q   <= '0;
                    mem_wmask_q  <= 8'h00;
                    mem_wdata_q  <= '0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= we_q ? '0 : ld_data;
                    resp_err_q   <= 1'b0;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = rst_n && (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_tag   = resp_tag_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_ce     = mem_ce_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wmask  = mem_wmask_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus random loads/stores
// checked against a byte-array memory model. Honours LSU_MISALIGN_CHK_EN.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.XLEN(64), .TAG_W(5)) bus ();

    lsu_ctrl #(.XLEN(64), .TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory seen by the DUT, and the bench's own byte-level model of it.
    logic [63:0] word_mem [16];
    logic [7:0]  ref_bytes [128];
    assign bus.mem_rdata = word_mem[bus.mem_addr[6:3]];

    int errors = 0;
    int checks = 0;

    int          ce_cnt, ce_k, resp_k;
    logic [63:0] cap_addr, cap_wdata, cap_rdata;
    logic [7:0]  cap_wmask;
    logic        cap_we, cap_err, mask_leak;
    logic [4:0]  cap_tag;

    function automatic logic ref_misaligned(input logic [63:0] a, input logic [1:0] sz);
`ifdef LSU_MISALIGN_CHK_EN
        int n = 1 << sz;
        return (int'(a[2:0]) % n) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz,
                                             input logic un);
        int n = 1 << sz;
        int off = int'(a[2:0]);
        logic [63:0] v = '0;
        if (ref_misaligned(a, sz)) return '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = ref_bytes[int'(a[6:0]) + i];
        if (!un && n < 8 && v[8*n-1])
            for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
        return v;
    endfunction

    task automatic ref_store(input logic [63:0] a, input logic [1:0] sz, input logic [63:0] wd);
        int n = 1 << sz;
        int off = int'(a[2:0]);
        if (!ref_misaligned(a, sz))
            for (int i = 0; i < n; i++)
                if (off + i < 8) ref_bytes[int'(a[6:0]) + i] = wd[8*i +: 8];
    endtask

    task automatic set_word(input int idx, input logic [63:0] val);
        word_mem[idx] = val;
        for (int b = 0; b < 8; b++) ref_bytes[8*idx + b] = val[8*b +: 8];
    endtask

    // Issues one request from a negedge in IDLE, acts as the memory, waits (bounded)
    // for the response, completes the handshake and returns at a negedge in IDLE.
    task automatic run_txn(input logic [63:0] a, input logic we, input logic [1:0] sz,
                           input logic un, input logic [63:0] wd, input logic [4:0] tg);
        ce_cnt = 0; ce_k = 0; resp_k = 0; mask_leak = 1'b0;
        bus.req_valid = 1'b1; bus.req_addr = a; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = un; bus.req_wdata = wd; bus.req_tag = tg;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!(bus.mem_ce && bus.mem_we) && bus.mem_wmask != 8'h00) mask_leak = 1'b1;
            if (bus.mem_ce) begin
                ce_cnt++; ce_k = k;
                cap_addr = bus.mem_addr; cap_we = bus.mem_we;
                cap_wmask = bus.mem_wmask; cap_wdata = bus.mem_wdata;
                if (bus.mem_we)
                    for (int b = 0; b < 8; b++)
                        if (bus.mem_wmask[b])
                            word_mem[bus.mem_addr[6:3]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
            end
            if (bus.resp_valid) begin
                resp_k = k;
                cap_rdata = bus.resp_rdata; cap_tag = bus.resp_tag; cap_err = bus.resp_err;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (resp_k == 0) begin
            errors++;
            $display("FAIL txn_timeout addr=%h: no resp_valid within 8 cycles", a);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_ce, bus.mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy/rv/err/ce/we=%b want 00000",
                     {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_ce, bus.mem_we});
        end
        checks++;
        if ({bus.resp_rdata, bus.resp_tag, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== '0) begin
            errors++;
            $display("FAIL reset_data got rdata=%h tag=%h addr=%h wdata=%h wmask=%h want all 0",
                     bus.resp_rdata, bus.resp_tag, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release req_ready got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_store_byte();
        run_txn(64'h8000_0003, 1'b1, SZ_B, 1'b0, 64'hAB, 5'd3);
        ref_store(64'h8000_0003, SZ_B, 64'hAB);
        checks++;
        if (cap_addr !== 64'h8000_0000 || cap_wmask !== 8'h08 ||
            cap_wdata !== 64'h0000_0000_AB00_0000 || cap_we !== 1'b1) begin
            errors++;
            $display("FAIL sb_access got addr=%h wmask=%h wdata=%h we=%b want 80000000 08 ab000000 1",
                     cap_addr, cap_wmask, cap_wdata, cap_we);
        end
        checks++;
        if (ce_cnt != 1 || ce_k != 1 || resp_k != 2) begin
            errors++;
            $display("FAIL sb_latency got ce_cnt=%0d ce_k=%0d resp_k=%0d want 1 1 2",
                     ce_cnt, ce_k, resp_k);
        end
        checks++;
        if (cap_rdata !== 64'h0 || cap_tag !== 5'd3 || cap_err !== 1'b0) begin
            errors++;
            $display("FAIL sb_resp got rdata=%h tag=%0d err=%b want 0 3 0", cap_rdata, cap_tag, cap_err);
        end
    endtask

    task automatic test_loads();
        set_word(0, 64'h0000_8000_0000_0000);
        run_txn(64'h8000_0005, 1'b0, SZ_B, 1'b0, 64'h0, 5'd1);
        checks++;
        if (cap_rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin
            errors++;
            $display("FAIL lb_signed got %h want ffffffffffffff80", cap_rdata);
        end
        run_txn(64'h8000_0005, 1'b0, SZ_B, 1'b1, 64'h0, 5'd2);
        checks++;
        if (cap_rdata !== 64'h80 || cap_tag !== 5'd2) begin
            errors++;
            $display("FAIL lbu got rdata=%h tag=%0d want 80 2", cap_rdata, cap_tag);
        end
        set_word(0, 64'h89AB_CDEF_0123_4567);
        run_txn(64'h8000_0004, 1'b0, SZ_W, 1'b0, 64'h0, 5'd4);
        checks++;
        if (cap_rdata !== 64'hFFFF_FFFF_89AB_CDEF || cap_wmask !== 8'h00 || mask_leak) begin
            errors++;
            $display("FAIL lw got rdata=%h wmask=%h leak=%b want ffffffff89abcdef 00 0",
                     cap_rdata, cap_wmask, mask_leak);
        end
        run_txn(64'h8000_0000, 1'b0, SZ_D, 1'b1, 64'h0, 5'd5);
        checks++;
        if (cap_rdata !== 64'h89AB_CDEF_0123_4567 || cap_wmask !== 8'h00 || cap_we !== 1'b0) begin
            errors++;
            $display("FAIL ld got rdata=%h wmask=%h we=%b want 89abcdef01234567 00 0",
                     cap_rdata, cap_wmask, cap_we);
        end
    endtask

    task automatic test_stall();
        set_word(1, 64'h1122_3344_5566_7788);
        bus.req_valid = 1'b1; bus.req_addr = 64'h8000_000C; bus.req_we = 1'b0;
        bus.req_size = SZ_W; bus.req_unsigned = 1'b1; bus.req_wdata = '0; bus.req_tag = 5'd7;
        @(negedge clk);
        bus.req_addr = 64'h8000_0008; bus.req_size = SZ_D; bus.req_tag = 5'd9;
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'h1122_3344 || bus.resp_tag !== 5'd7) begin
            errors++;
            $display("FAIL stall_first got rv=%b rdata=%h tag=%0d want 1 11223344 7",
                     bus.resp_valid, bus.resp_rdata, bus.resp_tag);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'h1122_3344 ||
                bus.resp_tag !== 5'd7 || bus.req_ready !== 1'b0 || bus.mem_ce !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold c=%0d got rv=%b rdata=%h tag=%0d rdy=%b ce=%b", c,
                         bus.resp_valid, bus.resp_rdata, bus.resp_tag, bus.req_ready, bus.mem_ce);
            end
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got rdy=%b rv=%b want 1 0", bus.req_ready, bus.resp_valid);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_ce !== 1'b1 || bus.mem_addr !== 64'h8000_0008) begin
            errors++;
            $display("FAIL stall_next_access got ce=%b addr=%h want 1 80000008", bus.mem_ce, bus.mem_addr);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'h1122_3344_5566_7788 ||
            bus.resp_tag !== 5'd9) begin
            errors++;
            $display("FAIL stall_next_resp got rv=%b rdata=%h tag=%0d want 1 1122334455667788 9",
                     bus.resp_valid, bus.resp_rdata, bus.resp_tag);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 1'b1; bus.req_addr = 64'h8000_0020; bus.req_we = 1'b1;
        bus.req_size = SZ_D; bus.req_unsigned = 1'b0; bus.req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        bus.req_tag = 5'd4;
        @(negedge clk);
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_ce !== 1'b1 || bus.mem_wmask !== 8'hFF) begin
            errors++;
            $display("FAIL rstmid_access got ce=%b wmask=%h want 1 ff", bus.mem_ce, bus.mem_wmask);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_ce, bus.mem_we, bus.mem_wmask, bus.mem_addr, bus.mem_wdata,
             bus.resp_valid, bus.req_ready} !== '0) begin
            errors++;
            $display("FAIL rstmid_clear got ce=%b we=%b wmask=%h addr=%h rv=%b rdy=%b want all 0",
                     bus.mem_ce, bus.mem_we, bus.mem_wmask, bus.mem_addr, bus.resp_valid,
                     bus.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_ready got %b want 1", bus.req_ready);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.resp_valid !== 1'b0 || bus.mem_ce !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stale c=%0d got rv=%b ce=%b want 0 0", c, bus.resp_valid,
                         bus.mem_ce);
            end
        end
    endtask

    task automatic test_misalign();
        run_txn(64'h8000_0001, 1'b1, SZ_H, 1'b0, 64'hBEEF, 5'd2);
        ref_store(64'h8000_0001, SZ_H, 64'hBEEF);
`ifdef LSU_MISALIGN_CHK_EN
        checks++;
        if (ce_cnt != 0 || resp_k != 1 || cap_err !== 1'b1 || cap_rdata !== 64'h0) begin
            errors++;
            $display("FAIL misalign_err got ce_cnt=%0d resp_k=%0d err=%b rdata=%h want 0 1 1 0",
                     ce_cnt, resp_k, cap_err, cap_rdata);
        end
`else
        checks++;
        if (cap_wmask !== 8'h06 || cap_wdata !== 64'h00BE_EF00 || resp_k != 2 || cap_err !== 1'b0) begin
            errors++;
            $display("FAIL misalign_sh got wmask=%h wdata=%h resp_k=%0d err=%b want 06 beef00 2 0",
                     cap_wmask, cap_wdata, resp_k, cap_err);
        end
`endif
    endtask

    task automatic test_random();
        logic [63:0] a, wd, exp_rdata;
        logic        we, un, exp_err;
        logic [1:0]  sz;
        logic [4:0]  tg;
        int          exp_k;
        for (int t = 0; t < 80; t++) begin
            a  = 64'h8000_0000 | 64'($urandom_range(0, 127));
            we = 1'($urandom);
            sz = 2'($urandom);
            un = 1'($urandom);
            wd = {$urandom, $urandom};
            tg = 5'($urandom);
            exp_err   = ref_misaligned(a, sz);
            exp_rdata = we ? 64'h0 : ref_load(a, sz, un);
            exp_k     = exp_err ? 1 : 2;
            run_txn(a, we, sz, un, wd, tg);
            if (we) ref_store(a, sz, wd);
            checks++;
            if (cap_rdata !== exp_rdata || cap_tag !== tg || cap_err !== exp_err) begin
                errors++;
                $display("FAIL rand_resp t=%0d addr=%h we=%b sz=%0d un=%b got rdata=%h tag=%0d err=%b want %h %0d %b",
                         t, a, we, sz, un, cap_rdata, cap_tag, cap_err, exp_rdata, tg, exp_err);
            end
            checks++;
            if (resp_k != exp_k || mask_leak) begin
                errors++;
                $display("FAIL rand_timing t=%0d got resp_k=%0d leak=%b want %0d 0", t, resp_k,
                         mask_leak, exp_k);
            end
        end
        for (int w = 0; w < 16; w++) begin
            logic [63:0] exp_w;
            for (int b = 0; b < 8; b++) exp_w[8*b +: 8] = ref_bytes[8*w + b];
            checks++;
            if (word_mem[w] !== exp_w) begin
                errors++;
                $display("FAIL mem_word w=%0d got %h want %h", w, word_mem[w], exp_w);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_wdata = '0; bus.req_tag = '0; bus.resp_ready = 1'b0;
        for (int w = 0; w < 16; w++) set_word(w, 64'h0);
        test_reset();
        test_store_byte();
        test_loads();
        test_stall();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
